// File: rtl/sort_job_ctrl_arb.sv
// Two-requester round-robin arbiter for the sort job controller.
// A lone valid requester always wins. On a tie the grant goes to whichever
// requester did not win the previous handshake. After reset, last_grant is 1,
// so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       hs,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant from the current valids and the previous winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner, but only when a job is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (hs) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/sort_job_ctrl.sv
// Shares one odd-even sorter between two requesters. Each accepted job holds
// the sorter enabled for SORT_CYCLES cycles on a latched vector. The sorter's
// max output is then captured and returned with the requester id.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid must stay asserted, with stable data, until that edge.
// ready may depend combinationally on valid; valid never depends on ready.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 8
`endif

module sort_job_ctrl #(
    parameter int ARRAYWIDTH  = `ARRAYWIDTH,
    parameter int DW          = `OUTPUT_BUF_DATASIZE,
    parameter int SORT_CYCLES = ARRAYWIDTH + 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ARRAYWIDTH*DW-1:0] req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ARRAYWIDTH*DW-1:0] req1_data,
    output logic                     sort_en,
    output logic [ARRAYWIDTH*DW-1:0] sort_in,
    input  logic [DW-1:0]            sort_max,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_id,
    output logic                     busy
);

    localparam int             CW       = $clog2(SORT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SORT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          hs;

    // A job is taken whenever the controller is idle and somebody is granted.
    assign hs         = (state == S_IDLE) && (grant != 2'b00);
    assign req0_ready = (state == S_IDLE) && grant[0];
    assign req1_ready = (state == S_IDLE) && grant[1];
    assign sort_en    = (state == S_RUN);
    assign busy       = (state != S_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid ({req1_valid, req0_valid}),
        .hs    (hs),
        .grant (grant)
    );

    // Job sequencing: latch vector, run the sorter, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sort_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        sort_in <= grant[1] ? req1_data : req0_data;
                        rsp_id  <= grant[1];
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The counter stops at its last value, so it never wraps.
                    if (cnt == CNT_LAST) begin
                        rsp_data  <= sort_max;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
